// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage plus the IF/ID pipeline register.
// Keeps the PC, issues one instruction-memory request at a time, parks a
// single returned word in a skid buffer while decode is stalled, and
// follows taken-branch redirects from downstream. A HALT_WORD stops fetch
// until a redirect or reset.
module fetch_unit #(
    parameter int unsigned          ADDR_W    = 24,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          PC_STEP   = 4,
    parameter logic [INSTR_W-1:0]   HALT_WORD = {INSTR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branchTakenFlag,
    input  logic [ADDR_W-1:0]  branchTarget,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instrIFID,
    output logic [ADDR_W-1:0]  pcIFID,
    output logic               validIFID,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    disc_addr_q, disc_addr_d;   // address of the abandoned request
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic                 ifid_vld_q, ifid_vld_d;

    logic                 load_en;
    logic [INSTR_W-1:0]   load_instr;
    logic [ADDR_W-1:0]    load_pc;
    logic                 rdata_is_halt;
    logic                 skid_is_halt;

    // Sequential PC advance; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_STEP);
    endfunction

    assign rdata_is_halt = (imem_rdata == HALT_WORD);
    assign skid_is_halt  = (skid_instr_q == HALT_WORD);

    // Next-state, PC, skid-buffer and IF/ID update logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        disc_addr_d  = disc_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_vld_d   = skid_vld_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_vld_d   = ifid_vld_q;
        load_en      = 1'b0;
        load_instr   = '0;
        load_pc      = '0;

        if (branchTakenFlag) begin
            // Redirect beats stall and everything else; IF/ID and skid are flushed.
            pc_d         = branchTarget;
            ifid_vld_d   = 1'b0;
            ifid_instr_d = '0;
            skid_vld_d   = 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        state_d = S_FETCH;
                    end else begin
                        // Request cannot be withdrawn: wait it out and drop its data.
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                S_DISCARD: begin
                    if (imem_valid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        // A halt word leaves the PC pointing at itself.
                        if (!rdata_is_halt) begin
                            pc_d = pc_inc(pc_q);
                        end
                        if (stall) begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            skid_vld_d   = 1'b1;
                            state_d      = S_HOLD;
                        end else begin
                            load_en    = 1'b1;
                            load_instr = imem_rdata;
                            load_pc    = pc_q;
                            state_d    = rdata_is_halt ? S_HALTED : S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && skid_vld_q) begin
                        load_en    = 1'b1;
                        load_instr = skid_instr_q;
                        load_pc    = skid_pc_q;
                        skid_vld_d = 1'b0;
                        state_d    = skid_is_halt ? S_HALTED : S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_valid) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (load_en) begin
                ifid_instr_d = load_instr;
                ifid_pc_d    = load_pc;
                ifid_vld_d   = 1'b1;
            end else if (!stall) begin
                // Nothing new for decode: insert a bubble.
                ifid_instr_d = '0;
                ifid_vld_d   = 1'b0;
            end
        end
    end

    // State, PC, skid buffer and IF/ID registers with async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            disc_addr_q  <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_vld_q   <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            disc_addr_q  <= disc_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_vld_q   <= skid_vld_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_vld_q   <= ifid_vld_d;
        end
    end

    // Memory interface and status outputs decoded from the state.
    always_comb begin
        imem_req  = (state_q == S_FETCH) || (state_q == S_DISCARD);
        imem_addr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
        halted    = (state_q == S_HALTED);
    end

    assign instrIFID = ifid_instr_q;
    assign pcIFID    = ifid_pc_q;
    assign validIFID = ifid_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A memory model answers
// requests after a programmable latency; each answered word is queued as
// an expected IF/ID delivery, and redirects flush or drop queued entries.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branchTakenFlag;
    logic [23:0] branchTarget;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instrIFID;
    logic [23:0] pcIFID;
    logic        validIFID;
    logic        halted;

    int          n_tests;
    int          n_fail;
    int          mem_lat;
    int          wait_cnt;
    logic        drop_next;
    logic [23:0] halt_addr;
    logic [55:0] exp_q[$];
    logic        exp_vld;
    logic [31:0] exp_instr;
    logic [23:0] exp_pc;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branchTakenFlag (branchTakenFlag),
        .branchTarget    (branchTarget),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_rdata      (imem_rdata),
        .instrIFID       (instrIFID),
        .pcIFID          (pcIFID),
        .validIFID       (validIFID),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        if (a == halt_addr) return 32'hFFFF_FFFF;
        case (a)
            24'h000000: return 32'h0000_0011;
            24'h000004: return 32'h0000_0022;
            24'h000008: return 32'h0000_0033;
            default:    return {8'hC0, a};
        endcase
    endfunction

    // One clock: memory model and inputs at negedge, scoreboard check after posedge.
    task automatic tick(input logic st, input logic br, input logic [23:0] tgt);
        logic [55:0] e;
        @(negedge clk);
        if (imem_valid) begin
            imem_valid = 1'b0;
            wait_cnt   = 0;
        end
        if (imem_req) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(imem_addr);
                if (drop_next) drop_next = 1'b0;
                else exp_q.push_back({imem_rdata, imem_addr});
            end
        end else begin
            wait_cnt = 0;
        end
        stall           = st;
        branchTakenFlag = br;
        branchTarget    = tgt;
        if (br) begin
            exp_q.delete();
            if (imem_req && !imem_valid) drop_next = 1'b1;
            exp_vld   = 1'b0;
            exp_instr = '0;
        end else if (!st) begin
            if (exp_q.size() > 0) begin
                e         = exp_q.pop_front();
                exp_vld   = 1'b1;
                exp_instr = e[55:24];
                exp_pc    = e[23:0];
            end else begin
                exp_vld   = 1'b0;
                exp_instr = '0;
            end
        end
        @(posedge clk);
        #1;
        check("validIFID", 64'(validIFID), 64'(exp_vld));
        check("instrIFID", 64'(instrIFID), 64'(exp_instr));
        if (exp_vld) check("pcIFID", 64'(pcIFID), 64'(exp_pc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_instr", 64'(instrIFID), 64'(0));
        check("rst_pc",    64'(pcIFID),    64'(0));
        check("rst_valid", 64'(validIFID), 64'(0));
        check("rst_halted",64'(halted),    64'(0));
        check("rst_req",   64'(imem_req),  64'(0));
        check("rst_addr",  64'(imem_addr), 64'(0));
        imem_valid      = 1'b0;
        wait_cnt        = 0;
        drop_next       = 1'b0;
        stall           = 1'b0;
        branchTakenFlag = 1'b0;
        exp_q.delete();
        exp_vld   = 1'b0;
        exp_instr = '0;
        exp_pc    = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; stall = 1'b0; branchTakenFlag = 1'b0; branchTarget = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        mem_lat = 1; wait_cnt = 0; drop_next = 1'b0;
        halt_addr = 24'hFFFF00;
        exp_vld = 1'b0; exp_instr = '0; exp_pc = '0;

        // Reset, then 1-cycle memory
        do_reset();
        @(posedge clk); #1;
        check("idle_to_fetch_req", 64'(imem_req), 64'(1));
        check("first_addr", 64'(imem_addr), 64'(0));
        tick(0, 0, '0);
        check("addr_4", 64'(imem_addr), 64'(24'h4));
        tick(0, 0, '0);
        check("addr_8", 64'(imem_addr), 64'(24'h8));

        // Stall while the response for 8 arrives
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, '0);
            check("hold_req", 64'(imem_req), 64'(0));
        end
        tick(0, 0, '0);
        check("after_hold_instr", 64'(instrIFID), 64'(32'h33));
        check("after_hold_addr", 64'(imem_addr), 64'(24'hC));
        check("after_hold_req", 64'(imem_req), 64'(1));

        // 4-cycle memory, redirect in the 2nd wait cycle
        mem_lat = 4;
        tick(0, 0, '0);
        tick(0, 1, 24'h100);
        check("disc_addr_a", 64'(imem_addr), 64'(24'hC));
        check("disc_req_a", 64'(imem_req), 64'(1));
        tick(0, 0, '0);
        check("disc_addr_b", 64'(imem_addr), 64'(24'hC));
        tick(0, 0, '0);
        check("redir_addr", 64'(imem_addr), 64'(24'h100));
        check("redir_req", 64'(imem_req), 64'(1));
        for (int i = 0; i < 4; i++) tick(0, 0, '0);
        check("redir_first_pc", 64'(pcIFID), 64'(24'h100));

        // Redirect and stall together with a response
        mem_lat = 1;
        tick(1, 1, 24'h200);
        check("both_addr", 64'(imem_addr), 64'(24'h200));
        check("both_req", 64'(imem_req), 64'(1));
        tick(0, 0, '0);
        check("both_deliver_pc", 64'(pcIFID), 64'(24'h200));

        // Halt at 0x20, then restart at 0x40
        halt_addr = 24'h20;
        tick(0, 1, 24'h18);
        for (int i = 0; i < 3; i++) tick(0, 0, '0);
        check("halt_instr", 64'(instrIFID), 64'(32'hFFFF_FFFF));
        check("halt_pc", 64'(pcIFID), 64'(24'h20));
        check("halt_flag", 64'(halted), 64'(1));
        check("halt_req", 64'(imem_req), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, '0);
            check("halted_stays", 64'({halted, imem_req}), 64'(2'b10));
        end
        tick(0, 1, 24'h40);
        check("unhalt_flag", 64'(halted), 64'(0));
        check("unhalt_addr", 64'(imem_addr), 64'(24'h40));
        tick(0, 0, '0);

        // PC wrap, then reset in the middle of a discard
        tick(0, 1, 24'hFFFFFC);
        tick(0, 0, '0);
        check("wrap_addr", 64'(imem_addr), 64'(0));
        tick(0, 0, '0);
        mem_lat = 4;
        tick(0, 0, '0);
        tick(0, 1, 24'h300);
        check("disc2_addr", 64'(imem_addr), 64'(24'h4));
        do_reset();
        mem_lat = 1;
        @(posedge clk); #1;
        check("restart_addr", 64'(imem_addr), 64'(0));
        tick(0, 0, '0);
        check("restart_instr", 64'(instrIFID), 64'(32'h11));
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
